// File: rtl/switch_led_ctrl.sv
// Debounced switch bank driving an LED bank in one of four display modes
// (direct, blink, press-toggle, chase), using a shared blink timebase.
module switch_led_ctrl #(
  parameter int WIDTH           = 8,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int BLINK_DIV       = 25000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] switch,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] led,
  output logic [WIDTH-1:0] sw_db,
  output logic             tick
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam int DW = $clog2(BLINK_DIV);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [DW-1:0] DIV_MAX = DW'(BLINK_DIV - 1);

  logic [WIDTH-1:0]         s1, s2;
  logic [WIDTH-1:0][CW-1:0] cnt;
  logic [WIDTH-1:0]         sw_q, rise, tgl, chase;
  logic [DW-1:0]            div;
  logic                     phase;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= switch;
      s2 <= s1;
    end
  end

  // A level must differ from sw_db for DEBOUNCE_CYCLES straight cycles; any return restarts it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt   <= '0;
      sw_db <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (s2[i] == sw_db[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_MAX) begin
          sw_db[i] <= s2[i];
          cnt[i]   <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  // div is zero in reset, so tick is low there without needing its own flop.
  assign tick = (div == DIV_MAX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div   <= '0;
      phase <= 1'b0;
      chase <= WIDTH'(1);
    end else begin
      div   <= tick ? '0 : div + 1'b1;
      phase <= phase ^ tick;
      if (tick) chase <= (chase << 1) | (chase >> (WIDTH - 1));
    end
  end

  assign rise = sw_db & ~sw_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sw_q <= '0;
      tgl  <= '0;
    end else begin
      sw_q <= sw_db;
      tgl  <= tgl ^ rise;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      led <= '0;
    end else begin
      case (mode)
        2'b00:   led <= sw_db;
        2'b01:   led <= sw_db & {WIDTH{phase}};
        2'b10:   led <= tgl;
        default: led <= chase & sw_db;
      endcase
    end
  end

endmodule

// File: tb/tb_switch_led_ctrl.sv
// Directed bench for switch_led_ctrl with WIDTH=8, DEBOUNCE_CYCLES=4, BLINK_DIV=5;
// e counts rising edges since the last reset release.
module tb_switch_led_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] switch = '0;
  logic [1:0] mode = '0;
  logic [7:0] led, sw_db;
  logic       tick;

  int n_checks = 0;
  int n_fail   = 0;
  int e        = 0;

  switch_led_ctrl #(.WIDTH(8), .DEBOUNCE_CYCLES(4), .BLINK_DIV(5)) dut (
    .clk(clk), .rst(rst), .switch(switch), .mode(mode),
    .led(led), .sw_db(sw_db), .tick(tick)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h (edge %0d)", tag, obs, exp, e);
    end
  endtask

  task automatic run_to(input int n);
    while (e < n) begin
      @(posedge clk);
      #1;
      e++;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    e = 0;
  endtask

  initial begin
    // reset values, asserted between edges
    #1 rst = 1'b1;
    #2;
    chk("rst_led", led, 0);
    chk("rst_sw_db", sw_db, 0);
    chk("rst_tick", tick, 0);
    chk("rst_chase", dut.chase, 1);
    chk("rst_tgl", dut.tgl, 0);

    // mode 00: clean change accepted at edge 6, shown at edge 7
    mode = 2'b00;
    do_reset();
    switch = 8'hA5;
    run_to(4); chk("t1_tick_hi", tick, 1);
    run_to(5); chk("t1_tick_lo", tick, 0); chk("t1_db_e5", sw_db, 8'h00);
    run_to(6); chk("t1_db_e6", sw_db, 8'hA5); chk("t1_led_e6", led, 8'h00);
    run_to(7); chk("t1_led_e7", led, 8'hA5);

    // bounce: 3-cycle pulse rejected, 4-cycle hold accepted
    switch = 8'h00;
    do_reset();
    switch = 8'h01;
    run_to(3); switch = 8'h00;
    run_to(5);  chk("t2_db_e5", sw_db, 8'h00);
    run_to(6);  chk("t2_db_e6", sw_db, 8'h00);
    run_to(10); chk("t2_db_e10", sw_db, 8'h00); chk("t2_led_e10", led, 8'h00);
    switch = 8'h01;
    run_to(14); switch = 8'h00;
    run_to(15); chk("t2_db_e15", sw_db, 8'h00);
    run_to(16); chk("t2_db_e16", sw_db, 8'h01);
    run_to(17); chk("t2_led_e17", led, 8'h01);

    // mode 01: blink with 5-cycle phases
    mode = 2'b01;
    do_reset();
    switch = 8'hFF;
    run_to(6); chk("t3_db", sw_db, 8'hFF);
    for (int n = 7; n <= 20; n++) begin
      run_to(n);
      chk("t3_led", led, (((n - 1) / 5) % 2) ? 32'hFF : 32'h00);
      chk("t3_tick", tick, (n % 5 == 4) ? 32'd1 : 32'd0);
    end

    // mode 11: chase masked by sw_db
    mode = 2'b11;
    switch = 8'h00;
    do_reset();
    switch = 8'hFF;
    for (int n = 7; n <= 46; n++) begin
      run_to(n);
      chk("t5_chase_ff", led, 32'd1 << (((n - 1) / 5) % 8));
    end
    switch = 8'h0F;
    run_to(52); chk("t5_db_0f", sw_db, 8'h0F);
    for (int n = 53; n <= 90; n++) begin
      run_to(n);
      chk("t5_chase_0f", led, (32'd1 << (((n - 1) / 5) % 8)) & 32'h0F);
    end

    // mode 10: press toggle, mode swap keeps tgl
    mode = 2'b10;
    switch = 8'h00;
    do_reset();
    switch = 8'h08;
    run_to(6); chk("t4_db_p1", sw_db, 8'h08);
    run_to(7); chk("t4_led_e7", led, 8'h00); chk("t4_tgl_e7", dut.tgl, 8'h08);
    run_to(8); chk("t4_led_e8", led, 8'h08);
    mode = 2'b11;
    run_to(9); chk("t4_led_m11", led, 8'h00);
    mode = 2'b10;
    run_to(10); chk("t4_led_back", led, 8'h08);
    switch = 8'h00;
    run_to(16); chk("t4_db_r1", sw_db, 8'h00);
    switch = 8'h08;
    run_to(22); chk("t4_db_p2", sw_db, 8'h08);
    run_to(23); chk("t4_led_e23", led, 8'h08);
    run_to(24); chk("t4_led_e24", led, 8'h00);
    switch = 8'h00;
    run_to(30); chk("t4_db_r2", sw_db, 8'h00);
    switch = 8'h08;
    run_to(36); chk("t4_db_p3", sw_db, 8'h08);
    run_to(38); chk("t4_led_e38", led, 8'h08); chk("t4_tgl_e38", dut.tgl, 8'h08);
    switch = 8'h00;
    run_to(41);

    // async reset mid-debounce, before the next edge
    #3 rst = 1'b1;
    #1;
    chk("ar_led", led, 8'h00);
    chk("ar_sw_db", sw_db, 8'h00);
    chk("ar_tgl", dut.tgl, 8'h00);
    chk("ar_chase", dut.chase, 8'h01);
    chk("ar_tick", tick, 0);

    // switches held high through reset count as a fresh change
    switch = 8'h30;
    @(posedge clk);
    #1;
    rst = 1'b0;
    e = 0;
    run_to(5); chk("hr_db_e5", sw_db, 8'h00);
    run_to(6); chk("hr_db_e6", sw_db, 8'h30);
    run_to(7); chk("hr_led_e7", led, 8'h00);
    run_to(8); chk("hr_led_e8", led, 8'h30);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
